// File: rtl/seg_bcd_encoder_if.sv
// Input handshake bundle for seg_bcd_encoder.
// in_data/in_valid flow source->encoder, in_ready flows back.
interface seg_bcd_encoder_if #(
    parameter int IN_W = 7
);
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/seg_bcd_encoder.sv
// Binary (0..127) to two-digit seven-segment encoder using a
// sequential double-dabble engine; values >=100 show dashes.
// Ports: clk, rst (sync, active-high), bus (slave: in_data,
// in_valid, in_ready), both7seg[13:0] {tens,units}, done, ovf.
// Option: define SEG_LZ_BLANK_EN to blank a leading zero tens digit.
module seg_bcd_encoder #(
    parameter int         IN_W     = 7,
    parameter logic [6:0] DASH_PAT = 7'h40
) (
    input  logic                clk,
    input  logic                rst,
    seg_bcd_encoder_if.slave    bus,
    output logic [13:0]         both7seg,
    output logic                done,
    output logic                ovf
);

    localparam int SR_W = IN_W + 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

    state_t          state;
    logic            ready_q;
    logic [SR_W-1:0] sreg;
    logic [2:0]      cnt;
    logic            ovf_next;

    logic [SR_W-1:0] adj;
    logic [3:0]      tens;
    logic [3:0]      units;
    logic [6:0]      tens_pat;
    logic [6:0]      units_pat;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] p;
        unique case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign tens  = sreg[SR_W-1 -: 4];
    assign units = sreg[SR_W-5 -: 4];

    // Both nibbles are corrected from their pre-shift values.
    always_comb begin
        adj = {add3(tens), add3(units), sreg[IN_W-1:0]};
    end

    always_comb begin
        units_pat = enc(units);
`ifdef SEG_LZ_BLANK_EN
        tens_pat = (tens == 4'd0) ? 7'h00 : enc(tens);
`else
        tens_pat = enc(tens);
`endif
    end

    assign bus.in_ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            sreg     <= '0;
            cnt      <= 3'd0;
            ovf_next <= 1'b0;
            both7seg <= 14'h0000;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && ready_q) begin
                        sreg     <= {8'd0, bus.in_data};
                        ovf_next <= (bus.in_data >= IN_W'(100));
                        cnt      <= 3'd7;
                        state    <= SHIFT;
                        ready_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sreg <= adj << 1;
                    cnt  <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (ovf_next) begin
                        both7seg <= {DASH_PAT, DASH_PAT};
                        ovf      <= 1'b1;
                    end else begin
                        both7seg <= {tens_pat, units_pat};
                        ovf      <= 1'b0;
                    end
                    done    <= 1'b1;
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bcd_encoder.sv
// Self-checking bench for seg_bcd_encoder: vector table, corner
// sequences and a full sweep, checked through a result scoreboard.
module tb_seg_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] both7seg;
    logic        done;
    logic        ovf;

    always #5 clk = ~clk;

    seg_bcd_encoder_if bus_if ();

    seg_bcd_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .both7seg (both7seg),
        .done     (done),
        .ovf      (ovf)
    );

`ifdef SEG_LZ_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    typedef struct {
        logic [13:0] seg;
        logic        ov;
        int          cyc;
        int          din;
    } exp_t;

    typedef struct {
        logic [6:0]  din;
        logic [13:0] seg;
        logic        ov;
    } vec_t;

    exp_t q[$];
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic ref_seg(input int v, output logic [13:0] s,
                           output logic o);
        logic [6:0] t;
        if (v >= 100) begin
            s = {7'h40, 7'h40};
            o = 1'b1;
        end else begin
            t = (v / 10 == 0) ? LZ : code(v / 10);
            s = {t, code(v % 10)};
            o = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: every done pops one expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && done) begin
            if (prev_done) begin
                chk("done_width", 1, 0);
            end
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk($sformatf("seg_in%0d", e.din), int'(both7seg),
                    int'(e.seg));
                chk($sformatf("ovf_in%0d", e.din), int'(ovf), int'(e.ov));
                chk($sformatf("latency_in%0d", e.din), cyc - e.cyc, 8);
            end
        end
        prev_done = done;
    end

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send(input int v, input bit push,
                        input logic [13:0] es, input logic eo);
        exp_t e;
        bus_if.in_data  = 7'(v);
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.in_ready) begin
                @(posedge clk);
                #1;
                if (push) begin
                    e.seg = es;
                    e.ov  = eo;
                    e.cyc = cyc;
                    e.din = v;
                    q.push_back(e);
                end
                chk("ready_drop", int'(bus_if.in_ready), 0);
                @(negedge clk);
                bus_if.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("handshake_timeout", 1, 0);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_ref(input int v);
        logic [13:0] s;
        logic        o;
        ref_seg(v, s, o);
        send(v, 1'b1, s, o);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{7'd42,  {7'h66, 7'h5B}, 1'b0};
        vecs[1] = '{7'd7,   {LZ,    7'h07}, 1'b0};
        vecs[2] = '{7'd99,  {7'h6F, 7'h6F}, 1'b0};
        vecs[3] = '{7'd100, {7'h40, 7'h40}, 1'b1};
        vecs[4] = '{7'd0,   {LZ,    7'h3F}, 1'b0};
        vecs[5] = '{7'd127, {7'h40, 7'h40}, 1'b1};
        vecs[6] = '{7'd10,  {7'h06, 7'h3F}, 1'b0};
        vecs[7] = '{7'd19,  {7'h06, 7'h6F}, 1'b0};
        vecs[8] = '{7'd58,  {7'h6D, 7'h7F}, 1'b0};
        vecs[9] = '{7'd81,  {7'h7F, 7'h06}, 1'b0};

        bus_if.in_data  = '0;
        bus_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", int'(both7seg), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_ready", int'(bus_if.in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send(int'(vecs[i].din), 1'b1, vecs[i].seg, vecs[i].ov);
            drain();
        end

        // Back-to-back 99 then 100.
        send(99, 1'b1, {7'h6F, 7'h6F}, 1'b0);
        send(100, 1'b1, {7'h40, 7'h40}, 1'b1);
        drain();

        // in_valid held through SHIFT with changing data.
        bus_if.in_data  = 7'd33;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.seg = {7'h4F, 7'h4F};
        e.ov  = 1'b0;
        e.cyc = cyc;
        e.din = 33;
        q.push_back(e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_if.in_data = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        drain();

        // Reset in the 4th SHIFT cycle of 55.
        send(55, 1'b0, 14'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_seg", int'(both7seg), 0);
        chk("abort_ready", int'(bus_if.in_ready), 1);
        chk("abort_done", int'(done), 0);
        repeat (12) @(negedge clk);
        send(0, 1'b1, {LZ, 7'h3F}, 1'b0);
        drain();

        // Reset together with in_valid: no transfer.
        bus_if.in_data  = 7'd5;
        bus_if.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("rstvalid_ready", int'(bus_if.in_ready), 1);
        chk("rstvalid_seg", int'(both7seg), 0);
        repeat (12) @(negedge clk);

        // Full sweep, back-to-back.
        for (int v = 0; v < 128; v++) begin
            send_ref(v);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
